sleep_timer: RTL and testbench
==============================

# sleep_timer

Parametrised successor to the lock controller's sleep divider. On `sleep` it counts to a programmable terminal value, then issues a single-cycle `end_sleep` pulse to the controller. It supports one-shot and periodic (auto-reload) modes and abort on `sleep` deassertion. An optional prescaler stretches each count step to several clocks.

## Interface
- `WIDTH`, default 4: counter and terminal-value width.
- `PRESCALE_DIV`, default 1: clocks per count step; used only when `SLEEP_TIMER_PRESCALE_EN` is defined; legal range 1..65535.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sleep` in 1: level; high requests and holds the timer; low aborts or re-arms.
- `load_val` in WIDTH: terminal count, sampled only at start.
- `periodic` in 1: sampled at start; 0 means one-shot, 1 means auto-reload.
- `end_sleep` out 1: one-cycle pulse at terminal count.
- `busy` out 1: high while in COUNT.
- `count` out WIDTH: current counter value.

## Operation
- Three states: IDLE, COUNT, DONE. Registers: `state`, `count`, `tc_q`, `mode_q`, `end_sleep`.
- Reset (async) forces:
  - `state`=IDLE;
  - `count`=0, `tc_q`=0, `mode_q`=0;
  - `end_sleep`=0, `busy`=0;
  - prescaler counter = 0.
- IDLE with `sleep`=1 at an edge:
  - `tc_q`<=`load_val`, `mode_q`<=`periodic`, `count`<=0;
  - go to COUNT.
- IDLE with `sleep`=0: hold; `count` stays 0.
- COUNT: on each step tick, evaluate in this priority order:
  - `sleep`=0: go to IDLE, `count`<=0, no pulse. Abort beats terminal count in the same cycle.
  - `count`==`tc_q`, `mode_q`=0: `end_sleep`<=1, go to DONE, `count` holds `tc_q`.
  - `count`==`tc_q`, `mode_q`=1: `end_sleep`<=1, `count`<=0, stay in COUNT.
  - otherwise: `count`<=`count`+1.
- COUNT without a tick: hold, except that `sleep`=0 aborts regardless of tick.
- DONE:
  - `end_sleep`<=0;
  - hold until `sleep`=0, then go to IDLE with `count`<=0.
  - `sleep` must drop before a new start, so a held `sleep` never retriggers.
- `end_sleep` is cleared in every cycle it is not explicitly set; it is never high for two consecutive cycles.
- `load_val`=0 is legal: the pulse follows on the first tick.
- `load_val` and `periodic` changes during COUNT or DONE are ignored.
- `count` never exceeds `tc_q`, so no wrap-around is possible. The increment is WIDTH bits wide with the carry discarded.
- `busy` = (`state`==COUNT), registered-state decode.

## Timing
- All outputs are registered, except that `busy` decodes the state register.
- Start edge E0 is the edge where IDLE samples `sleep`=1.
- One-shot pulse:
  - `end_sleep` is high in the cycle following edge E0+`tc_q`+1;
  - latency from E0 = `tc_q`+1 clocks (× `PRESCALE_DIV` with prescaler).
  - With default WIDTH=4 and `load_val`=15, that is 16 clocks.
- Periodic mode: pulses every (`tc_q`+1) ticks with no gap cycle.
- Abort: `busy` falls the cycle after the edge sampling `sleep`=0.
- Async reset mid-operation: outputs clear immediately, without a clock edge. Release is synchronous to the next `clk` edge.

## Configuration
- `SLEEP_TIMER_PRESCALE_EN` defined:
  - a prescaler counter produces one tick every `PRESCALE_DIV` clocks while in COUNT;
  - it is cleared to 0 on entry to COUNT, on abort, and in IDLE/DONE.
- Not defined:
  - the tick is constant 1, so the timer steps every clock;
  - `PRESCALE_DIV` is ignored and no prescaler logic is synthesised.

## Structure
- Shared package `lock_timer_pkg` holds:
  - `timer_state_t` (IDLE, COUNT, DONE);
  - `timer_mode_t` (ONE_SHOT, PERIODIC).
- Sub-module `tick_prescaler` (params `DIV`; ports `clk`, `reset`, `clear`, `tick`) is instantiated only under the macro.

## Test plan
- One-shot: WIDTH=4, `load_val`=15, `periodic`=0, `sleep` held high → exactly one `end_sleep` pulse, 16 clocks after E0; then `busy`=0 and `count`=15 held; no second pulse.
- Periodic: `load_val`=3, `periodic`=1, `sleep` held for 14 clocks → pulses at E0+4, +8 and +12; `count` sequence 0,1,2,3,0…
- Abort: `load_val`=10, `sleep` dropped when `count`=5 → IDLE, `count`=0, `busy`=0, no pulse. Re-raising `sleep` restarts from 0.
- Edge values and retrigger:
  - `load_val`=0 → pulse at E0+1.
  - Changing `load_val` to 2 mid-count has no effect.
  - Holding `sleep` high in DONE gives no retrigger.
- Reset: async `reset` pulse between edges at `count`=7 → `count`, `busy` and `end_sleep` read 0 before the next edge.
- Prescaler (macro defined, `PRESCALE_DIV`=4, `load_val`=2) → pulse at E0+12 clocks; `count` advances every 4th clock.

Source files
------------

// File: rtl/lock_timer_pkg.sv
// Shared types for the lock controller's timers: state encoding and count mode.
package lock_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } timer_state_t;

    typedef enum logic {
        ONE_SHOT,
        PERIODIC
    } timer_mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Step-tick generator: one tick every DIV clocks, restarted whenever clear is high.
module tick_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] div_cnt;

    // DIV=1 keeps div_cnt at 0, so tick stays high every clock.
    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (clear || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 16'd1;
    end

endmodule

// File: rtl/sleep_timer.sv
// Sleep timer: counts to a sampled terminal value, pulses end_sleep, one-shot or periodic.
// Optional step prescaler enabled by defining SLEEP_TIMER_PRESCALE_EN.
module sleep_timer
    import lock_timer_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int PRESCALE_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sleep,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    output logic             end_sleep,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    timer_state_t     state, state_next;
    timer_mode_t      mode_q, mode_next;
    logic [WIDTH-1:0] tc_q, tc_next, count_next;
    logic             end_next;
    logic             tick;

`ifdef SLEEP_TIMER_PRESCALE_EN
    // Restart the step period on entry to COUNT, on abort, and outside COUNT.
    tick_prescaler #(
        .DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear((state != COUNT) || !sleep),
        .tick (tick)
    );
`else
    logic unused_div;
    assign unused_div = (PRESCALE_DIV != 0);
    assign tick       = 1'b1;
`endif

    assign busy = (state == COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            tc_q      <= '0;
            mode_q    <= ONE_SHOT;
            end_sleep <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            tc_q      <= tc_next;
            mode_q    <= mode_next;
            end_sleep <= end_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        tc_next    = tc_q;
        mode_next  = mode_q;
        end_next   = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                if (sleep) begin
                    tc_next    = load_val;
                    mode_next  = timer_mode_t'(periodic);
                    state_next = COUNT;
                end
            end
            COUNT: begin
                // Abort wins over terminal count and does not wait for a tick.
                if (!sleep) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (tick) begin
                    if (count == tc_q) begin
                        end_next = 1'b1;
                        if (mode_q == PERIODIC)
                            count_next = '0;
                        else
                            state_next = DONE;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!sleep) begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sleep_timer.sv
// Scoreboard bench for sleep_timer: expected pulse cycles queued at start, popped on each pulse.
module tb_sleep_timer;

    localparam int W = 4;
`ifdef SLEEP_TIMER_PRESCALE_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         sleep;
    logic         periodic;
    logic [W-1:0] load_val;
    logic         end_sleep;
    logic         busy;
    logic [W-1:0] count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0     = 0;
    int exp_q[$];

    sleep_timer #(
        .WIDTH       (W),
        .PRESCALE_DIV(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sleep    (sleep),
        .load_val (load_val),
        .periodic (periodic),
        .end_sleep(end_sleep),
        .busy     (busy),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every pulse must match the oldest queued expectation; unexpected pulses fail.
    always @(negedge clk) begin
        int e;
        if (end_sleep) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cyc", cyc, e);
            end
        end
    end

    // Called at a negedge; the following posedge is the start edge E0.
    task automatic start(input logic [W-1:0] lv, input logic per);
        @(negedge clk);
        load_val = lv;
        periodic = per;
        sleep    = 1'b1;
        e0       = cyc + 1;
    endtask

    // Advance to the negedge following edge E0+k.
    task automatic wait_k(input int k);
        while (cyc < e0 + k) @(negedge clk);
    endtask

    task automatic stop();
        sleep = 1'b0;
        @(negedge clk);
        chk("stop_count", count, 0);
        chk("stop_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        sleep    = 1'b0;
        periodic = 1'b0;
        load_val = '0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_end", end_sleep, 0);
        @(negedge clk);
        reset = 1'b0;

        // one-shot, full range
        start(4'd15, 1'b0);
        exp_q.push_back(e0 + 16 * D);
        wait_k(0);
        chk("os_busy0", busy, 1);
        chk("os_count0", count, 0);
        wait_k(8 * D);
        chk("os_count8", count, 8);
        wait_k(16 * D);
        chk("os_done_busy", busy, 0);
        chk("os_done_count", count, 15);
        wait_k(16 * D + 6);
        chk("os_hold_count", count, 15);
        stop();

        // periodic, tc=3, sleep held 14 steps
        start(4'd3, 1'b1);
        exp_q.push_back(e0 + 4 * D);
        exp_q.push_back(e0 + 8 * D);
        exp_q.push_back(e0 + 12 * D);
        for (int k = 0; k < 14 * D; k++) begin
            wait_k(k);
            chk("per_count", count, (k / D) % 4);
        end
        wait_k(14 * D);
        stop();

        // abort at count 5, then restart from 0
        start(4'd10, 1'b0);
        wait_k(5 * D);
        chk("ab_count5", count, 5);
        stop();
        repeat (12 * D) @(negedge clk);
        start(4'd10, 1'b0);
        exp_q.push_back(e0 + 11 * D);
        wait_k(0);
        chk("ab_restart_count", count, 0);
        chk("ab_restart_busy", busy, 1);
        wait_k(11 * D + 2);
        chk("ab_done_count", count, 10);
        chk("ab_done_busy", busy, 0);
        stop();

        // terminal value 0
        start(4'd0, 1'b0);
        exp_q.push_back(e0 + D);
        wait_k(D + 3);
        chk("z_busy", busy, 0);
        chk("z_count", count, 0);
        stop();

        // terminal value 2
        start(4'd2, 1'b0);
        exp_q.push_back(e0 + 3 * D);
        wait_k(D);
        chk("t2_count1", count, 1);
        wait_k(3 * D + 1);
        stop();

        // inputs changed mid-count are ignored; held sleep in DONE never retriggers
        start(4'd5, 1'b0);
        exp_q.push_back(e0 + 6 * D);
        wait_k(1);
        load_val = 4'd2;
        periodic = 1'b1;
        wait_k(6 * D + 10);
        chk("mc_busy", busy, 0);
        chk("mc_count", count, 5);
        stop();
        periodic = 1'b0;

        // asynchronous reset between edges
        start(4'd15, 1'b0);
        wait_k(7 * D);
        chk("ar_count7", count, 7);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_end", end_sleep, 0);
        sleep = 1'b0;
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ar_post_count", count, 0);
        chk("ar_post_busy", busy, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
